multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder of the 16-bit RISC core. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, drives the same datapath control set (alu_op, reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg) per state, and adds ready/valid handshakes to instruction and data memory with a data-memory timeout. Sits between the instruction register and the datapath; the ALU `zero` flag feeds back for branches.

---
 rtl/multicycle_control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC core: FETCH/DECODE/EXEC/MEM/WB
// sequencing with imem/dmem ready handshakes and a bounded data-memory wait.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  input  logic                imem_ready_i,
  input  logic                dmem_ready_i,
  output logic                imem_rd_o,
  output logic                ir_wr_o,
  output logic                pc_wr_o,
  output logic [1:0]          pc_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_o,
  output logic                reg_dst_o,
  output logic                jump_o,
  output logic                cmp_o,
  output logic                reg_wr_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  output logic                mem_to_reg_o,
  output logic                instr_done_o,
  output logic                illegal_op_o,
  output logic                mem_timeout_o,
  output logic [2:0]          state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any set bit above the 4 decoded opcode bits makes the instruction illegal.
  logic op_hi_nz;
  generate
    if (OPCODE_W > 4) begin : g_op_hi
      assign op_hi_nz = |opcode_i[OPCODE_W-1:4];
    end else begin : g_op_no_hi
      assign op_hi_nz = 1'b0;
    end
  endgenerate

  logic op_legal;
  assign op_legal = !op_hi_nz && (opcode_i[3:0] <= OP_JMP);

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_jmp;
  assign is_rtype = (op_q <= OP_SLT);
  assign is_addi  = (op_q == OP_ADDI);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_jmp   = (op_q == OP_JMP);

  // Datapath controls implied by the latched opcode; EXEC drives them and
  // MEM keeps the address-generating ALU setup stable during the access.
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src, ex_reg_dst, ex_cmp, ex_jump;

  always_comb begin
    ex_alu_op  = '0;
    ex_alu_src = 1'b0;
    ex_reg_dst = 1'b0;
    ex_cmp     = 1'b0;
    ex_jump    = 1'b0;
    if (is_rtype) begin
      ex_alu_op  = ALU_OP_W'(op_q[2:0]);
      ex_reg_dst = 1'b1;
    end else if (is_addi || is_lw || is_sw) begin
      ex_alu_src = 1'b1;
    end else if (is_beq) begin
      ex_alu_op  = ALU_OP_W'(3'd1);
      ex_cmp     = 1'b1;
    end else if (is_jmp) begin
      ex_jump    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    imem_rd_o     = 1'b0;
    ir_wr_o       = 1'b0;
    pc_wr_o       = 1'b0;
    pc_src_o      = 2'd0;
    alu_op_o      = '0;
    alu_src_o     = 1'b0;
    reg_dst_o     = 1'b0;
    jump_o        = 1'b0;
    cmp_o         = 1'b0;
    reg_wr_o      = 1'b0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;
    mem_to_reg_o  = 1'b0;
    instr_done_o  = 1'b0;
    illegal_op_o  = 1'b0;
    mem_timeout_o = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_rd_o = 1'b1;
        if (imem_ready_i) begin
          ir_wr_o  = 1'b1;
          pc_wr_o  = 1'b1;
          pc_src_o = 2'd0;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d = opcode_i[3:0];
        if (!op_legal) begin
          illegal_op_o = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op_o  = ex_alu_op;
        alu_src_o = ex_alu_src;
        reg_dst_o = ex_reg_dst;
        cmp_o     = ex_cmp;
        jump_o    = ex_jump;
        if (is_rtype || is_addi) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (is_beq) begin
          if (zero_i) begin
            pc_wr_o  = 1'b1;
            pc_src_o = 2'd1;
          end
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end else if (is_jmp) begin
          pc_wr_o      = 1'b1;
          pc_src_o     = 2'd2;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        alu_op_o  = ex_alu_op;
        alu_src_o = ex_alu_src;
        mem_rd_o  = is_lw;
        mem_wr_o  = is_sw;
        // The strobe stays up through the last allowed wait cycle so a
        // completion landing exactly at the limit still wins over the abort.
        if (dmem_ready_i) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
          mem_timeout_o = 1'b1;
          state_d       = S_FETCH;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        reg_wr_o     = 1'b1;
        mem_to_reg_o = is_lw;
        reg_dst_o    = ex_reg_dst;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: runs hand-picked instructions
// and compares latencies, strobe counts and per-state controls.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode_i;
  logic       zero_i, imem_ready_i, dmem_ready_i;
  logic       imem_rd_o, ir_wr_o, pc_wr_o;
  logic [1:0] pc_src_o;
  logic [2:0] alu_op_o;
  logic       alu_src_o, reg_dst_o, jump_o, cmp_o, reg_wr_o;
  logic       mem_rd_o, mem_wr_o, mem_to_reg_o;
  logic       instr_done_o, illegal_op_o, mem_timeout_o;
  logic [2:0] state_o;

  multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .zero_i(zero_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_rd_o(imem_rd_o), .ir_wr_o(ir_wr_o), .pc_wr_o(pc_wr_o),
    .pc_src_o(pc_src_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
    .reg_dst_o(reg_dst_o), .jump_o(jump_o), .cmp_o(cmp_o),
    .reg_wr_o(reg_wr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_to_reg_o(mem_to_reg_o), .instr_done_o(instr_done_o),
    .illegal_op_o(illegal_op_o), .mem_timeout_o(mem_timeout_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [21:0] all_outs;
  assign all_outs = {imem_rd_o, ir_wr_o, pc_wr_o, pc_src_o, alu_op_o, alu_src_o,
                     reg_dst_o, jump_o, cmp_o, reg_wr_o, mem_rd_o, mem_wr_o,
                     mem_to_reg_o, instr_done_o, illegal_op_o, mem_timeout_o,
                     state_o};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-instruction observations, refreshed by run_instr.
  int          n_cyc, end_cyc, rd_cnt, wr_cnt, done_cnt, ill_cnt, to_cnt;
  int          regwr_cnt, pcw_late, excl_err;
  logic [23:0] trace;
  logic        exec_pcwr, exec_jump, exec_alusrc, exec_cmp, wb_regdst, done_m2r, ended;
  logic [1:0]  exec_pcsrc;
  logic [2:0]  exec_aluop;

  // Starts in a FETCH cycle; runs until the next FETCH after the instruction.
  task automatic run_instr(input logic [3:0] op, input logic z, input int dmem_low);
    int mem_cyc;
    n_cyc = 0; end_cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; ill_cnt = 0;
    to_cnt = 0; regwr_cnt = 0; pcw_late = 0; trace = '0; ended = 1'b0;
    exec_pcwr = 0; exec_jump = 0; exec_alusrc = 0; exec_cmp = 0; exec_pcsrc = 0;
    exec_aluop = 0; wb_regdst = 0; done_m2r = 0;
    mem_cyc = 0;
    for (int g = 0; g < 64; g++) begin
      opcode_i     = op;
      zero_i       = z;
      imem_ready_i = 1'b1;
      dmem_ready_i = (state_o == 3'd4 && mem_cyc < dmem_low) ? 1'b0 : 1'b1;
      #1;
      if (state_o == 3'd1 && n_cyc > 0) begin
        ended = 1'b1;
        break;
      end
      n_cyc++;
      trace = {trace[20:0], state_o};
      if (mem_rd_o) rd_cnt++;
      if (mem_wr_o) wr_cnt++;
      if (reg_wr_o) regwr_cnt++;
      if (pc_wr_o && state_o != 3'd1) pcw_late++;
      if (instr_done_o) begin done_cnt++; end_cyc = n_cyc; done_m2r = mem_to_reg_o; end
      if (illegal_op_o) begin ill_cnt++; end_cyc = n_cyc; end
      if (mem_timeout_o) begin to_cnt++; end_cyc = n_cyc; end
      if (int'(instr_done_o) + int'(illegal_op_o) + int'(mem_timeout_o) > 1) excl_err++;
      if (state_o == 3'd3) begin
        exec_pcwr = pc_wr_o; exec_pcsrc = pc_src_o; exec_jump = jump_o;
        exec_alusrc = alu_src_o; exec_aluop = alu_op_o; exec_cmp = cmp_o;
      end
      if (state_o == 3'd5) wb_regdst = reg_dst_o;
      if (state_o == 3'd4) mem_cyc++;
      cyc();
    end
    $display("instr op=%0d zero=%0d dmem_low=%0d cycles=%0d done=%0d illegal=%0d timeout=%0d",
             op, z, dmem_low, end_cyc, done_cnt, ill_cnt, to_cnt);
    check_eq("returned_to_fetch", ended, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    excl_err = 0;
    rst_n = 1'b1; opcode_i = 4'd0; zero_i = 1'b0;
    imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_outs", all_outs, 22'd0);
    #5 rst_n = 1'b1;
    #1;
    check_eq("reset_state_held", state_o, 3'd0);
    cyc();
    check_eq("first_fetch", state_o, 3'd1);

    run_instr(4'd0, 1'b0, 0);
    check_eq("add_cycles", end_cyc, 4);
    check_eq("add_trace", trace, 24'h00029D);
    check_eq("add_done", done_cnt, 1);
    check_eq("add_regwr", regwr_cnt, 1);
    check_eq("add_wb_regdst", wb_regdst, 1'b1);
    check_eq("add_exec_aluop", exec_aluop, 3'd0);

    run_instr(4'd1, 1'b0, 0);
    check_eq("sub_exec_aluop", exec_aluop, 3'd1);
    check_eq("sub_cycles", end_cyc, 4);

    run_instr(4'd5, 1'b0, 0);
    check_eq("slt_exec_aluop", exec_aluop, 3'd5);

    run_instr(4'd6, 1'b0, 0);
    check_eq("addi_cycles", end_cyc, 4);
    check_eq("addi_alusrc", exec_alusrc, 1'b1);
    check_eq("addi_wb_regdst", wb_regdst, 1'b0);

    run_instr(4'd7, 1'b0, 3);
    check_eq("lw_cycles", end_cyc, 8);
    check_eq("lw_trace", trace, 24'h29C925);
    check_eq("lw_memrd", rd_cnt, 4);
    check_eq("lw_mem_to_reg", done_m2r, 1'b1);
    check_eq("lw_regwr", regwr_cnt, 1);

    run_instr(4'd8, 1'b0, 0);
    check_eq("sw_cycles", end_cyc, 4);
    check_eq("sw_memwr", wr_cnt, 1);
    check_eq("sw_done", done_cnt, 1);
    check_eq("sw_regwr", regwr_cnt, 0);

    run_instr(4'd8, 1'b0, 1000);
    check_eq("sw_to_memwr", wr_cnt, 16);
    check_eq("sw_to_pulse", to_cnt, 1);
    check_eq("sw_to_done", done_cnt, 0);
    check_eq("sw_to_cycles", end_cyc, 19);
    check_eq("sw_to_regwr", regwr_cnt, 0);

    run_instr(4'd8, 1'b0, 15);
    check_eq("sw_edge_memwr", wr_cnt, 16);
    check_eq("sw_edge_done", done_cnt, 1);
    check_eq("sw_edge_timeout", to_cnt, 0);

    run_instr(4'd9, 1'b1, 0);
    check_eq("beq_t_cycles", end_cyc, 3);
    check_eq("beq_t_pcwr", exec_pcwr, 1'b1);
    check_eq("beq_t_pcsrc", exec_pcsrc, 2'd1);
    check_eq("beq_t_cmp", exec_cmp, 1'b1);
    check_eq("beq_t_aluop", exec_aluop, 3'd1);
    check_eq("beq_t_done", done_cnt, 1);

    run_instr(4'd9, 1'b0, 0);
    check_eq("beq_nt_pcwr", exec_pcwr, 1'b0);
    check_eq("beq_nt_done", done_cnt, 1);

    run_instr(4'd10, 1'b0, 0);
    check_eq("jmp_cycles", end_cyc, 3);
    check_eq("jmp_jump", exec_jump, 1'b1);
    check_eq("jmp_pcwr", exec_pcwr, 1'b1);
    check_eq("jmp_pcsrc", exec_pcsrc, 2'd2);

    for (int op = 11; op <= 15; op++) begin
      run_instr(4'(op), 1'b0, 0);
      check_eq("ill_cycles", end_cyc, 2);
      check_eq("ill_pulse", ill_cnt, 1);
      check_eq("ill_done", done_cnt, 0);
      check_eq("ill_side_effects", regwr_cnt + wr_cnt + pcw_late, 0);
    end
    check_eq("pulse_exclusive", excl_err, 0);

    // Reset asserted between clock edges while an SW is waiting in MEM.
    opcode_i = 4'd8; dmem_ready_i = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    check_eq("rst_pre_state", state_o, 3'd4);
    check_eq("rst_pre_memwr", mem_wr_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_memwr", mem_wr_o, 1'b0);
    check_eq("rst_async_state", state_o, 3'd0);
    check_eq("rst_async_outs", all_outs, 22'd0);
    imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
    cyc();
    check_eq("rst_hold_outs", all_outs, 22'd0);
    #2 rst_n = 1'b1;
    #1;
    check_eq("rst_release_state", state_o, 3'd0);
    cyc();
    check_eq("rst_then_fetch", state_o, 3'd1);
    check_eq("rst_then_imem_rd", imem_rd_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
